// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_ctrl
//  Description : Shared debouncer sample tick, per-button SHORT/LONG/REPEAT
//                classification, fixed-priority arbitration into a small
//                event FIFO drained through a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_event_ctrl #(
    parameter int NUM_BTN    = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1_000,
    parameter int LONG_TK    = 1000,
    parameter int REP_TK     = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       o_tick,
    input  logic [NUM_BTN-1:0]         i_btn_level,
    output logic                       o_evt_valid,
    output logic [$clog2(NUM_BTN)-1:0] o_evt_btn,
    output logic [1:0]                 o_evt_type,
    input  logic                       i_evt_ready,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf
);

    localparam int c_DIV     = CLK_HZ / TICK_HZ;
    localparam int c_TW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    // Hold counter must reach whichever of the two thresholds is larger
    localparam int c_CNT_MAX = (LONG_TK > REP_TK) ? LONG_TK : REP_TK;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam int c_BW      = $clog2(NUM_BTN);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_PW      = c_AW + 1;
    localparam int c_EW      = c_BW + 2;

    localparam logic [1:0] c_EVT_SHORT  = 2'b00;
    localparam logic [1:0] c_EVT_LONG   = 2'b01;
    localparam logic [1:0] c_EVT_REPEAT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [c_TW-1:0] r_tick_cnt;
    logic            w_tick;

    assign w_tick = (r_tick_cnt == c_TW'(c_DIV - 1));
    assign o_tick = w_tick;

    // Free-running divider, wraps to 0 on the tick cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-button classification FSMs
    // ------------------------------------------------------------------
    state_t             r_state      [NUM_BTN];
    state_t             w_state_nxt  [NUM_BTN];
    logic [c_CW-1:0]    r_cnt        [NUM_BTN];
    logic [c_CW-1:0]    w_cnt_nxt    [NUM_BTN];
    logic [1:0]         w_raise_type [NUM_BTN];
    logic [1:0]         r_raise_type [NUM_BTN];
    logic [NUM_BTN-1:0] w_raise;
    logic [NUM_BTN-1:0] r_raise;
    logic [NUM_BTN-1:0] r_armed;

    // Next state, hold count and raised event; release beats a same-cycle tick
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_raise[i]      = 1'b0;
            w_raise_type[i] = c_EVT_SHORT;
            case (r_state[i])
                S_IDLE: begin
                    if (r_armed[i] && i_btn_level[i]) begin
                        w_state_nxt[i] = S_PRESS;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                S_PRESS: begin
                    if (!i_btn_level[i]) begin
                        w_state_nxt[i]  = S_IDLE;
                        w_raise[i]      = 1'b1;
                        w_raise_type[i] = c_EVT_SHORT;
                    end else if (w_tick) begin
                        if (r_cnt[i] == c_CW'(LONG_TK - 1)) begin
                            w_state_nxt[i]  = S_HELD;
                            w_cnt_nxt[i]    = '0;
                            w_raise[i]      = 1'b1;
                            w_raise_type[i] = c_EVT_LONG;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (!i_btn_level[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt[i] == c_CW'(REP_TK - 1)) begin
                            w_cnt_nxt[i]    = '0;
                            w_raise[i]      = 1'b1;
                            w_raise_type[i] = c_EVT_REPEAT;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // State registers; a button arms once it has been seen released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i]      <= S_IDLE;
                r_cnt[i]        <= '0;
                r_raise_type[i] <= c_EVT_SHORT;
            end
            r_raise <= '0;
            r_armed <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i]      <= w_state_nxt[i];
                r_cnt[i]        <= w_cnt_nxt[i];
                r_raise_type[i] <= w_raise_type[i];
            end
            r_raise <= w_raise;
            r_armed <= r_armed | ~i_btn_level;
        end
    end

    // ------------------------------------------------------------------
    // Pending registers, arbiter and event FIFO
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_pend_v;
    logic [1:0]         r_pend_type [NUM_BTN];
    logic [NUM_BTN-1:0] w_grant;
    logic [c_BW-1:0]    w_grant_idx;
    logic               w_push;
    logic               w_pop;
    logic               w_can_push;
    logic               w_full;
    logic               w_empty;
    logic               w_ovf_set;
    logic               r_overflow;
    logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop      = !w_empty && i_evt_ready;
    assign w_can_push = !w_full || w_pop;
    // A pending event is lost only if it is not leaving this cycle
    assign w_ovf_set  = |(r_raise & r_pend_v & ~w_grant);

    // Lowest-index pending wins whenever the FIFO can take an entry
    always_comb begin
        w_grant_idx = '0;
        w_push      = 1'b0;
        w_grant     = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_pend_v[i]) begin
                w_grant_idx = c_BW'(i);
                w_push      = w_can_push;
            end
        end
        if (w_push) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // Pending slots: a new raise overwrites, a grant clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_v <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_pend_type[i] <= c_EVT_SHORT;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_raise[i]) begin
                    r_pend_v[i]    <= 1'b1;
                    r_pend_type[i] <= r_raise_type[i];
                end else if (w_grant[i]) begin
                    r_pend_v[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flag; setting wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Event FIFO storage and wrapping pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= {w_grant_idx, r_pend_type[w_grant_idx]};
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_evt_valid            = !w_empty;
    assign {o_evt_btn, o_evt_type} = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_overflow             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event_ctrl
//  Description : Self-checking bench for btn_event_ctrl: table of press
//                durations, directed multi-cycle sequences and randomized
//                levels against a behavioural event model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_event_ctrl;

    localparam int NUM_BTN    = 4;
    localparam int CLK_HZ     = 1000;
    localparam int TICK_HZ    = 100;
    localparam int LONG_TK    = 5;
    localparam int REP_TK     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = CLK_HZ / TICK_HZ;
    localparam int BW         = $clog2(NUM_BTN);

    logic               clk = 1'b0;
    logic               reset;
    logic               o_tick;
    logic [NUM_BTN-1:0] level;
    logic               o_evt_valid;
    logic [BW-1:0]      o_evt_btn;
    logic [1:0]         o_evt_type;
    logic               ready;
    logic               o_overflow;
    logic               clr;

    btn_event_ctrl #(
        .NUM_BTN   (NUM_BTN),
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .LONG_TK   (LONG_TK),
        .REP_TK    (REP_TK),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .o_tick     (o_tick),
        .i_btn_level(level),
        .o_evt_valid(o_evt_valid),
        .o_evt_btn  (o_evt_btn),
        .o_evt_type (o_evt_type),
        .i_evt_ready(ready),
        .o_overflow (o_overflow),
        .i_clr_ovf  (clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: events are encoded btn*4+type
    int m_cyc;
    bit m_armed   [NUM_BTN];
    bit m_pressed [NUM_BTN];
    int m_held    [NUM_BTN];
    bit m_str_v   [NUM_BTN];
    int m_str_t   [NUM_BTN];
    bit m_pend_v  [NUM_BTN];
    int m_pend_t  [NUM_BTN];
    int m_fifo[$];
    bit m_ovf;
    int popped[$];

    typedef struct {
        int          btn;
        int          ticks;
        int          n;
        logic [15:0] exp;   // nibble k = k-th expected event
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_ovf = 0;
        m_fifo.delete();
        for (int i = 0; i < NUM_BTN; i++) begin
            m_armed[i] = 0; m_pressed[i] = 0; m_held[i] = 0;
            m_str_v[i] = 0; m_str_t[i] = 0; m_pend_v[i] = 0; m_pend_t[i] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_update();
        bit tick, pop, can_push, ovf_set;
        int g;
        bit new_v [NUM_BTN];
        int new_t [NUM_BTN];
        if (!reset) begin
            model_reset();
            return;
        end
        tick     = (m_cyc % DIV) == DIV - 1;
        pop      = (m_fifo.size() > 0) && ready;
        can_push = (m_fifo.size() < FIFO_DEPTH) || pop;
        g = -1;
        if (can_push)
            for (int i = 0; i < NUM_BTN; i++)
                if (m_pend_v[i] && g < 0) g = i;
        for (int i = 0; i < NUM_BTN; i++) begin
            new_v[i] = 0; new_t[i] = 0;
            if (!m_pressed[i]) begin
                if (m_armed[i] && level[i]) begin m_pressed[i] = 1; m_held[i] = 0; end
            end else if (!level[i]) begin
                m_pressed[i] = 0;
                if (m_held[i] < LONG_TK) new_v[i] = 1;
            end else if (tick) begin
                m_held[i]++;
                if (m_held[i] == LONG_TK) begin new_v[i] = 1; new_t[i] = 1; end
                else if (m_held[i] > LONG_TK && (m_held[i] - LONG_TK) % REP_TK == 0) begin
                    new_v[i] = 1; new_t[i] = 2;
                end
            end
            if (!level[i]) m_armed[i] = 1;
        end
        ovf_set = 0;
        for (int i = 0; i < NUM_BTN; i++)
            if (m_str_v[i] && m_pend_v[i] && i != g) ovf_set = 1;
        if (ovf_set) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pop) void'(m_fifo.pop_front());
        if (g >= 0) begin
            m_fifo.push_back(g * 4 + m_pend_t[g]);
            m_pend_v[g] = 0;
        end
        for (int i = 0; i < NUM_BTN; i++)
            if (m_str_v[i]) begin m_pend_v[i] = 1; m_pend_t[i] = m_str_t[i]; end
        m_str_v = new_v;
        m_str_t = new_t;
        m_cyc++;
    endtask

    task automatic compare();
        if (!reset) begin
            check("rst_tick",  o_tick, 0);
            check("rst_valid", o_evt_valid, 0);
            check("rst_btn",   o_evt_btn, 0);
            check("rst_type",  o_evt_type, 0);
            check("rst_ovf",   o_overflow, 0);
        end else begin
            check("tick",  o_tick, ((m_cyc % DIV) == DIV - 1) ? 1 : 0);
            check("valid", o_evt_valid, (m_fifo.size() > 0) ? 1 : 0);
            if (m_fifo.size() > 0) check("head", {o_evt_btn, o_evt_type}, m_fifo[0]);
            check("ovf",   o_overflow, m_ovf ? 1 : 0);
        end
    endtask

    // One clock: log a DUT pop, update model, sample on the falling edge
    task automatic step();
        if (o_evt_valid && ready) popped.push_back(int'({o_evt_btn, o_evt_type}));
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic wait_tick_phase();
        for (int k = 0; k < 2 * DIV && !o_tick; k++) step();
        check("tick_seen", o_tick, 1);
    endtask

    task automatic press_for_ticks(input int btn, input int ticks);
        wait_tick_phase();
        level[btn] = 1'b1;
        repeat (ticks * DIV + 1) step();
        level[btn] = 1'b0;
        repeat (30) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 3,  1, 16'h0004};   // SHORT
        vecs[1] = '{0, 12, 4, 16'h2221};   // LONG, REPEAT x3
        vecs[2] = '{2, 4,  1, 16'h0008};   // one tick short of LONG
        vecs[3] = '{2, 5,  1, 16'h0009};   // exactly LONG
        vecs[4] = '{3, 6,  1, 16'h000D};   // LONG, no repeat yet
        vecs[5] = '{3, 7,  2, 16'h00ED};   // first REPEAT
        vecs[6] = '{1, 0,  1, 16'h0004};   // one-cycle press

        reset = 1'b0; level = '0; ready = 1'b1; clr = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (4) step();
        reset = 1'b1;

        // Tick period straight out of reset
        for (int k = 1; k <= 3 * DIV; k++) begin
            step();
            check("tick_at", o_tick, (k % DIV == DIV - 1) ? 1 : 0);
        end

        // Press-duration table
        for (int v = 0; v < 7; v++) begin
            popped.delete();
            press_for_ticks(vecs[v].btn, vecs[v].ticks);
            check("vec_count", popped.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n && k < popped.size(); k++)
                check("vec_event", popped[k], int'(vecs[v].exp[4*k +: 4]));
        end

        // Simultaneous release: lower index first
        popped.delete();
        level[0] = 1'b1; level[2] = 1'b1;
        repeat (5) step();
        level[0] = 1'b0; level[2] = 1'b0;
        repeat (10) step();
        check("arb_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check("arb_first",  popped[0], 0);
            check("arb_second", popped[1], 8);
        end

        // Backpressure and overflow
        popped.delete();
        ready = 1'b0;
        repeat (6) begin
            level[3] = 1'b1; repeat (3) step();
            level[3] = 1'b0; repeat (3) step();
        end
        repeat (5) step();
        check("bp_ovf",   o_overflow, 1);
        check("bp_valid", o_evt_valid, 1);
        ready = 1'b1;
        repeat (15) step();
        check("bp_pops", popped.size(), 5);
        foreach (popped[k]) check("bp_event", popped[k], 12);
        clr = 1'b1; step(); clr = 1'b0; step();
        check("ovf_cleared", o_overflow, 0);

        // Button held through reset stays silent until re-pressed
        level[1] = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        popped.delete();
        repeat (40) step();
        check("arm_silent", popped.size(), 0);
        check("arm_empty",  o_evt_valid, 0);
        level[1] = 1'b0; repeat (2) step();
        level[1] = 1'b1; repeat (3) step();
        level[1] = 1'b0; repeat (10) step();
        check("arm_count", popped.size(), 1);
        if (popped.size() == 1) check("arm_event", popped[0], 4);

        // Randomized levels, ready and clear against the model
        for (int c = 0; c < 4000; c++) begin
            int tog;
            tog = (c < 1500) ? 8 : 60;
            for (int i = 0; i < NUM_BTN; i++)
                if ($urandom_range(0, tog - 1) == 0) level[i] = ~level[i];
            if (c % 500 < 150) ready = ($urandom_range(0, 3) == 0);
            else               ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            if (c == 2500) reset = 1'b0;
            if (c == 2503) reset = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
